// File: rtl/display_7_seg_mux.sv
// Time-multiplexed multi-digit 7-segment driver with a sequential
// double-dabble binary-to-BCD converter, leading-zero blanking and overflow dashes.
module display_7_seg_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int BIN_WIDTH      = 14,
  parameter int SCAN_DIV       = 25000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Load,
  input  logic [BIN_WIDTH-1:0]  i_Binary,
  input  logic                  i_Hex_Mode,
  input  logic                  i_Blank_Lz,
  output logic                  o_Busy,
  output logic                  o_Overflow,
  output logic [6:0]            o_Seg,
  output logic [NUM_DIGITS-1:0] o_Digit_En
);

  localparam int DISP_W = 4 * NUM_DIGITS;
  // floor(BIN_WIDTH * 0.3) + 1 decimal digits always hold 2^BIN_WIDTH - 1
  localparam int BCD_D  = (BIN_WIDTH * 3) / 10 + 1;
  localparam int BCD_W  = 4 * BCD_D;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int CNT_W  = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BIN_WIDTH - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_DASH = 7'h01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_D; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  state_t                  state_q, state_d;
  logic [BIN_WIDTH-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    hex_q, hex_d;
  logic                    lz_pend_q, lz_pend_d;
  logic                    blank_q, blank_d;
  logic [DISP_W-1:0]       disp_q, disp_d;
  logic                    ovf_q, ovf_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic [BCD_W+BIN_WIDTH-1:0] shift_p0;
  logic [BCD_W+DISP_W-1:0]    bcd_ext;
  logic [BIN_WIDTH+DISP_W-1:0] hex_ext;

  // Conversion control: load capture, shift/add-3 iterations, atomic commit
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    lz_pend_d = lz_pend_q;
    blank_d   = blank_q;
    disp_d    = disp_q;
    ovf_d     = ovf_q;
    shift_p0  = {dabble_adj(bcd_q), bin_q} << 1;
    bcd_ext   = {{DISP_W{1'b0}}, bcd_q};
    hex_ext   = {{DISP_W{1'b0}}, bin_q};
    case (state_q)
      S_IDLE: begin
        if (i_Load) begin
          bin_d     = i_Binary;
          bcd_d     = '0;
          cnt_d     = '0;
          hex_d     = i_Hex_Mode;
          lz_pend_d = i_Blank_Lz;
          state_d   = i_Hex_Mode ? S_COMMIT : S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = shift_p0[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
        bin_d = shift_p0[BIN_WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (hex_q) begin
          disp_d = hex_ext[DISP_W-1:0];
          ovf_d  = |(hex_ext >> DISP_W);
        end else begin
          disp_d = bcd_ext[DISP_W-1:0];
          ovf_d  = |(bcd_ext >> DISP_W);
        end
        blank_d = lz_pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [3:0] digit_val;
  logic       upper_zero;

  // Scan: prescaler, digit index, and the registered pin drive for the next cycle
  always_comb begin
    presc_d    = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
    idx_d      = idx_q;
    if (presc_q == PRE_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    digit_val  = disp_q[{idx_q, 2'b00} +: 4];
    upper_zero = (disp_q >> {idx_q, 2'b00}) == '0;
    if (ovf_q)                                     seg_d = SEG_DASH;
    else if (blank_q && idx_q != '0 && upper_zero) seg_d = 7'h00;
    else                                           seg_d = seg_encode(digit_val);
    seg_d = seg_d ^ SEG_OFF;
    dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hex_q     <= 1'b0;
      lz_pend_q <= 1'b1;
      blank_q   <= 1'b1;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      lz_pend_q <= lz_pend_d;
      blank_q   <= blank_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  // Conversion datapath carries no reset; every load reinitialises it
  always_ff @(posedge i_Clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  assign o_Busy     = (state_q != S_IDLE);
  assign o_Overflow = ovf_q;
  assign o_Seg      = seg_q;
  assign o_Digit_En = dig_q;

endmodule

// File: tb/tb_display_7_seg_mux.sv
// Bench for display_7_seg_mux: directed scenarios plus random loads, all
// outputs compared every cycle against an arithmetic reference model.
module tb_display_7_seg_mux;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int SD = 4;

  localparam logic [6:0] SEG_TBL [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          ld   = 1'b0;
  logic [BW-1:0] bin  = '0;
  logic          hexm = 1'b0;
  logic          blz  = 1'b1;
  logic          busy;
  logic          ovf;
  logic [6:0]    seg;
  logic [ND-1:0] dig;

  int n_checks = 0;
  int n_errors = 0;

  display_7_seg_mux #(
    .NUM_DIGITS(ND), .BIN_WIDTH(BW), .SCAN_DIV(SD),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Load(ld), .i_Binary(bin),
    .i_Hex_Mode(hexm), .i_Blank_Lz(blz),
    .o_Busy(busy), .o_Overflow(ovf), .o_Seg(seg), .o_Digit_En(dig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: segment pattern of digit s for value v under the given mode
  function automatic logic [6:0] seg_of(input int v, input bit hx, input bit bl, input int s);
    int base;
    base = hx ? 16 : 10;
    if (v >= base ** ND) return 7'h01;
    if (bl && s > 0 && v < base ** s) return 7'h00;
    return SEG_TBL[(v / (base ** s)) % base];
  endfunction

  int            k, busy_left, pend_val, m_val;
  bit            pend_hex, pend_blank, m_hex, m_blank;
  logic [6:0]    m_seg;
  logic [ND-1:0] m_dig;
  logic          m_busy, m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0; busy_left <= 0; pend_val <= 0; pend_hex <= 1'b0; pend_blank <= 1'b1;
      m_val <= 0; m_hex <= 1'b0; m_blank <= 1'b1;
      m_seg <= 7'h00; m_dig <= '0; m_busy <= 1'b0; m_ovf <= 1'b0;
    end else begin
      m_dig <= ND'(1) << ((k / SD) % ND);
      m_seg <= seg_of(m_val, m_hex, m_blank, (k / SD) % ND);
      k     <= k + 1;
      if (busy_left != 0) begin
        busy_left <= busy_left - 1;
        m_busy    <= (busy_left != 1);
        if (busy_left == 1) begin
          m_val   <= pend_val;
          m_hex   <= pend_hex;
          m_blank <= pend_blank;
          m_ovf   <= pend_val >= (pend_hex ? 16 ** ND : 10 ** ND);
        end
      end else if (ld) begin
        pend_val   <= int'(bin);
        pend_hex   <= hexm;
        pend_blank <= blz;
        busy_left  <= hexm ? 1 : BW + 1;
        m_busy     <= 1'b1;
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_seg", 32'(seg), 32'(m_seg));
    chk("model_dig", 32'(dig), 32'(m_dig));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_ovf", 32'(ovf), 32'(m_ovf));
  end

  task automatic load(input int v, input bit hx, input bit bl);
    @(negedge clk);
    ld = 1'b1; bin = BW'(v); hexm = hx; blz = bl;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("idle", 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  task automatic show(input int i, input logic [6:0] exp);
    int n;
    n = 0;
    while (dig !== (ND'(1) << i) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dig%0d", i), 32'(dig), 32'(ND'(1) << i));
    chk($sformatf("seg%0d", i), 32'(seg), 32'(exp));
  endtask

  task automatic show4(input logic [6:0] d0, input logic [6:0] d1,
                       input logic [6:0] d2, input logic [6:0] d3);
    show(0, d0); show(1, d1); show(2, d2); show(3, d3);
  endtask

  initial begin
    int n;
    int v;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    show4(7'h7E, 7'h00, 7'h00, 7'h00);
    chk("idle_busy", 32'(busy), 32'(0));

    load(1234, 1'b0, 1'b1);
    busy_len(n);
    chk("busy_dec_len", 32'(n), 32'(15));
    wait_idle();
    show4(7'h33, 7'h79, 7'h6D, 7'h30);
    chk("ovf_1234", 32'(ovf), 32'(0));

    load(9999, 1'b0, 1'b1);
    wait_idle();
    show4(7'h7B, 7'h7B, 7'h7B, 7'h7B);
    load(10000, 1'b0, 1'b1);
    wait_idle();
    show4(7'h01, 7'h01, 7'h01, 7'h01);
    chk("ovf_10000", 32'(ovf), 32'(1));
    load(5, 1'b0, 1'b1);
    wait_idle();
    show4(7'h5B, 7'h00, 7'h00, 7'h00);
    chk("ovf_5", 32'(ovf), 32'(0));

    load(32'h2AF, 1'b1, 1'b1);
    busy_len(n);
    chk("busy_hex_len", 32'(n), 32'(1));
    wait_idle();
    show4(7'h47, 7'h77, 7'h6D, 7'h00);
    load(32'h2AF, 1'b1, 1'b0);
    wait_idle();
    show(3, 7'h7E);

    load(105, 1'b0, 1'b1);
    wait_idle();
    show4(7'h5B, 7'h7E, 7'h30, 7'h00);

    load(1234, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    ld = 1'b1; bin = BW'(42); hexm = 1'b0;
    @(negedge clk);
    ld = 1'b0;
    wait_idle();
    show4(7'h33, 7'h79, 7'h6D, 7'h30);

    load(5678, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_seg", 32'(seg), 32'(0));
    chk("rst_dig", 32'(dig), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    show(0, 7'h7E);
    show(1, 7'h00);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0:       v = 0;
        1:       v = 9999;
        2:       v = 10000;
        3:       v = 16383;
        default: v = int'($urandom_range(0, 16383));
      endcase
      load(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle();
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_7_seg_mux.md
Name: display_7_seg_mux

Overview:
- Parametrised, time-multiplexed multi-digit 7-segment driver; next generation of the team's single-digit combinational decoder.
- Accepts a binary value and shows it in decimal or hex across NUM_DIGITS common-anode/cathode digits.
- Decimal mode uses a sequential double-dabble converter. Adds leading-zero blanking, an overflow indication and selectable output polarity.
- Sits between counter/datapath logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- BIN_WIDTH, 14, width of i_Binary (1..27).
- SCAN_DIV, 25000, clocks each digit stays enabled (>=2).
- SEG_ACTIVE_LOW, 0, 1 inverts o_Seg at the pins.
- DIG_ACTIVE_LOW, 0, 1 inverts o_Digit_En at the pins.

Ports:
- i_Clk  in  1  system clock, all state on rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Load  in  1  one-cycle strobe: capture i_Binary, i_Hex_Mode, i_Blank_Lz.
- i_Binary  in  BIN_WIDTH  unsigned value to display.
- i_Hex_Mode  in  1  1 = hex digits, 0 = decimal.
- i_Blank_Lz  in  1  1 = blank leading zeros.
- o_Busy  out  1  conversion in progress; loads are ignored.
- o_Overflow  out  1  value does not fit in NUM_DIGITS digits.
- o_Seg  out  7  segments a..g = bits 6..0, registered.
- o_Digit_En  out  NUM_DIGITS  one-hot digit enable, bit 0 = least-significant digit, registered.

Behaviour:

Reset (asynchronous):
- Display register = 0, blank-LZ flag = 1, hex flag = 0.
- Prescaler = 0, digit index = 0.
- o_Busy = 0, o_Overflow = 0.
- o_Seg = all segments off; o_Digit_En = all inactive (polarity applied).
- Takes effect immediately, including mid-conversion; an aborted conversion is discarded.

Load acceptance:
- i_Load is accepted only when o_Busy = 0. A load asserted while busy is dropped; there is no queueing.

Conversion latency:
- Decimal, load accepted at edge T: o_Busy = 1 from T+1 for BIN_WIDTH+1 cycles (BIN_WIDTH shift/add-3 cycles, then 1 commit cycle). The display register and o_Overflow update at the commit edge. o_Busy = 0 in the following cycle.
- Hex: o_Busy = 1 for exactly 1 cycle (commit).
- The old value stays displayed until commit; the update is atomic across all digits.

Overflow:
- Decimal: value >= 10^NUM_DIGITS. Hex: value >= 16^NUM_DIGITS (possible only when BIN_WIDTH > 4*NUM_DIGITS).
- On overflow every digit shows dash (7'h01) and o_Overflow = 1. o_Overflow clears on the next non-overflowing commit.

Scan:
- Prescaler counts 0..SCAN_DIV-1. At terminal count the digit index advances, wrapping NUM_DIGITS-1 -> 0.
- Scanning is free-running and is not disturbed by loads or commits.
- Outputs are registered: 1-cycle lag from the index.

Encoding (before polarity), digit values 0..F:
- 0..9: 7E 30 6D 79 33 5B 5F 70 7F 7B.
- A..F: 77 1F 4E 3D 4F 47.
- Blank = 00.

Blanking:
- With the blank-LZ flag set, digits above the most-significant nonzero digit are blanked.
- Digit 0 is never blanked, so a value of 0 shows "0".
- Internal zeros are always shown.
- Blanking does not apply to overflow dashes.

Polarity:
- Applied only at the output register: SEG_ACTIVE_LOW/DIG_ACTIVE_LOW invert all bits.
- Reset values are "off" in the chosen polarity.

Test Plan:
(All scenarios use NUM_DIGITS=4, BIN_WIDTH=14, SCAN_DIV=4, active-high.)
1. Release reset, no load -> o_Digit_En steps 0001,0010,0100,1000 (4 clocks each) and wraps. o_Seg = 7E on digit 0, 00 on digits 1-3. o_Busy = 0.
2. Load 1234 decimal, i_Blank_Lz=1 -> o_Busy high 15 cycles. Then digits 0..3 show 33,79,6D,30. o_Overflow = 0.
3. Load 9999 -> 7B on all digits. Then load 10000 -> 01 on all digits, o_Overflow = 1. Then load 5 -> 5B,00,00,00, o_Overflow = 0.
4. Hex load 0x2AF, i_Blank_Lz=1 -> o_Busy for 1 cycle, then digits show 47,77,6D,00. Repeat with i_Blank_Lz=0 -> digit 3 shows 7E.
5. Decimal load 105, i_Blank_Lz=1 -> digits show 5B,7E,30,00 (internal zero kept).
6. Load 1234, second i_Load (value 42) at busy cycle 5 -> ignored, 1234 displayed. Then start a new load and assert i_Rst at busy cycle 7 -> o_Busy, o_Seg, o_Digit_En all 0 in the same cycle. After release, digit 0 shows 7E.
